uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex UART block: independent transmit and receive paths sharing one clock and one synchronous reset.
- Frame format: 1 start bit (low), WORD data bits sent LSB first, 1 stop bit (high), no parity. Line idles high.
- Bit timing comes from a fixed clocks-per-bit divider.
- Sits between a parallel host interface (byte strobe in, byte strobe out) and the serial pins.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per serial bit (e.g. 125 MHz / 115200 baud); must be >= 4.
- WORD, 9, data bits per frame; widths of i_Tx_Byte and o_Rx_Byte.

Ports:
- i_Clock  in  1  single system clock, all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Tx_DV  in  1  one-cycle strobe; i_Tx_Byte is valid, start a transmit.
- i_Tx_Byte  in  WORD  data word to transmit.
- o_Tx_Active  out  1  high from start bit through end of stop bit.
- o_Tx_Serial  out  1  serial TX line; idles high.
- o_Tx_Done  out  1  one-cycle pulse when the stop bit completes.
- i_Rx_Serial  in  1  asynchronous serial RX line; idles high.
- o_Rx_DV  out  1  one-cycle pulse; o_Rx_Byte is valid.
- o_Rx_Byte  out  WORD  last received word; held until the next frame completes.

Behaviour:
- Reset (synchronous): o_Tx_Serial=1; o_Tx_Active, o_Tx_Done, o_Rx_DV = 0; o_Rx_Byte = 0; both FSMs go to IDLE with counters cleared.
- Reset mid-frame aborts the frame immediately: TX line returns high next cycle; no Done or DV pulse is issued.
- Both FSMs use states IDLE, START, DATA, STOP, CLEANUP.
- Each FSM has a clock counter 0..CLKS_PER_BIT-1 and a bit index 0..WORD-1.

TX path:
- IDLE: line high. On i_Tx_DV=1, latch i_Tx_Byte and go to START. o_Tx_Active rises the next cycle.
- START: drive 0 for exactly CLKS_PER_BIT cycles.
- DATA: drive latched bit[idx] for CLKS_PER_BIT cycles each, idx 0 up to WORD-1.
- STOP: drive 1 for CLKS_PER_BIT cycles. On the last cycle, pulse o_Tx_Done for 1 cycle and deassert o_Tx_Active.
- CLEANUP: one cycle, then IDLE. Back-to-back frames are therefore separated by at least one idle cycle.
- i_Tx_DV outside IDLE is ignored; the latched word is unaffected.

RX path:
- i_Rx_Serial passes through a 2-flop synchronizer before any use.
- IDLE: wait for a synchronized low, then go to START.
- START: at count (CLKS_PER_BIT-1)/2 (mid-bit), re-check the line.
  - Still low: reset the counter and go to DATA.
  - High (glitch): return to IDLE.
- DATA: sample every CLKS_PER_BIT cycles from the mid-start point and shift into bit[idx], LSB first.
- STOP: wait CLKS_PER_BIT cycles to the stop mid-point, then update o_Rx_Byte and pulse o_Rx_DV for 1 cycle.
- CLEANUP: one cycle, then IDLE. A low in the stop-bit position is still accepted in the base build.
- Tolerance: frames whose bit period differs by up to ±2% from CLKS_PER_BIT, or whose data starts up to 1 µs late after the start bit, must decode correctly under mid-bit sampling.
- TX and RX are fully independent: simultaneous activity is allowed, and an external loopback of TX to RX must work.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - RX checks the stop-bit sample.
  - Sample 0: o_Rx_DV is suppressed, o_Rx_Byte is not updated, and a new output o_Rx_Frame_Err (1 bit) pulses for one cycle.
- Not defined: the port is absent and the stop-bit value is ignored.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, CLEANUP);
  - default constants for CLKS_PER_BIT and WORD;
  - a function for the mid-bit count.
- One sub-module, uart_bit_timer: a counter with a CLKS_PER_BIT-1 terminal pulse and a mid-bit pulse, instantiated once in TX and once in RX.

Test Plan:
- Reset with lines idle -> o_Tx_Serial=1, all strobes 0, o_Rx_Byte=0.
- Clock 8 ns, CLKS_PER_BIT=1085, WORD=9; i_Tx_DV pulse with i_Tx_Byte=0x0AB:
  - start bit of 1085 cycles, then bits 1,1,0,1,0,1,0,1,0, then stop;
  - o_Tx_Done pulses once, 11*1085 cycles after start;
  - o_Tx_Active covers exactly that span.
- Drive RX frame 0x03F at 8600 ns/bit with 1000 ns extra after the start bit -> one o_Rx_DV pulse; o_Rx_Byte=0x03F before the stop bit ends.
- 200 ns low glitch on i_Rx_Serial -> return to IDLE; no o_Rx_DV.
- i_Tx_DV re-asserted with 0x155 mid-frame -> ignored; frame 0x0AB completes unchanged.
- Loopback o_Tx_Serial->i_Rx_Serial sending 0x1FF then 0x000 -> o_Rx_Byte matches each word; i_Reset asserted mid-frame -> no Done/DV pulse, line high next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transceiver: FSM state encoding,
// default bit timing / word size, and the mid-bit sample point.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 1085;
    localparam int WORD_DEF         = 9;

    // Count value at which a bit is sampled in its centre.
    function automatic int mid_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps at CLKS_PER_BIT-1 (o_Last) and flags the mid-bit
// count (o_Mid). i_Clear holds the count at zero.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    output logic o_Last,
    output logic o_Mid
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(mid_bit(CLKS_PER_BIT));

    logic [CW-1:0] r_Count;

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear || o_Last)
            r_Count <= '0;
        else
            r_Count <= r_Count + CW'(1);
    end

    assign o_Last = (r_Count == LAST);
    assign o_Mid  = (r_Count == MID);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1-style UART (WORD data bits, no parity) with independent TX/RX FSMs.
// Optional UART_RX_FRAME_ERR_EN: reject frames with a low stop bit and pulse o_Rx_Frame_Err.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int WORD         = WORD_DEF
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Tx_DV,
    input  logic [WORD-1:0] i_Tx_Byte,
    output logic            o_Tx_Active,
    output logic            o_Tx_Serial,
    output logic            o_Tx_Done,
    input  logic            i_Rx_Serial,
    output logic            o_Rx_DV,
`ifdef UART_RX_FRAME_ERR_EN
    output logic            o_Rx_Frame_Err,
`endif
    output logic [WORD-1:0] o_Rx_Byte
);

    localparam int            IW       = (WORD > 1) ? $clog2(WORD) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD - 1);

    // ---------------- TX path ----------------
    uart_state_t     r_Tx_State;
    logic [WORD-1:0] r_Tx_Data;
    logic [IW-1:0]   r_Tx_Idx;
    logic [IW-1:0]   w_Tx_Next_Idx;
    logic            r_Tx_Serial, r_Tx_Active, r_Tx_Done;
    logic            w_Tx_Last, w_Tx_Mid_unused;

    assign w_Tx_Next_Idx = r_Tx_Idx + IW'(1);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Clear (r_Tx_State == IDLE),
        .o_Last  (w_Tx_Last),
        .o_Mid   (w_Tx_Mid_unused)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Tx_State  <= IDLE;
            r_Tx_Data   <= '0;
            r_Tx_Idx    <= '0;
            r_Tx_Serial <= 1'b1;
            r_Tx_Active <= 1'b0;
            r_Tx_Done   <= 1'b0;
        end else begin
            r_Tx_Done <= 1'b0;
            case (r_Tx_State)
                IDLE: begin
                    r_Tx_Serial <= 1'b1;
                    r_Tx_Idx    <= '0;
                    if (i_Tx_DV) begin
                        r_Tx_Data   <= i_Tx_Byte;
                        r_Tx_Serial <= 1'b0;
                        r_Tx_Active <= 1'b1;
                        r_Tx_State  <= START;
                    end
                end
                START: if (w_Tx_Last) begin
                    r_Tx_Serial <= r_Tx_Data[0];
                    r_Tx_State  <= DATA;
                end
                DATA: if (w_Tx_Last) begin
                    if (r_Tx_Idx == LAST_IDX) begin
                        r_Tx_Serial <= 1'b1;
                        r_Tx_State  <= STOP;
                    end else begin
                        r_Tx_Idx    <= w_Tx_Next_Idx;
                        r_Tx_Serial <= r_Tx_Data[w_Tx_Next_Idx];
                    end
                end
                STOP: if (w_Tx_Last) begin
                    r_Tx_Done   <= 1'b1;
                    r_Tx_Active <= 1'b0;
                    r_Tx_State  <= CLEANUP;
                end
                CLEANUP: r_Tx_State <= IDLE;
                default: r_Tx_State <= IDLE;
            endcase
        end
    end

    assign o_Tx_Serial = r_Tx_Serial;
    assign o_Tx_Active = r_Tx_Active;
    assign o_Tx_Done   = r_Tx_Done;

    // ---------------- RX path ----------------
    uart_state_t     r_Rx_State;
    logic            r_Rx_Sync1, r_Rx_Sync2;
    logic [WORD-1:0] r_Rx_Data, r_Rx_Byte;
    logic [IW-1:0]   r_Rx_Idx;
    logic            r_Rx_DV;
    logic            w_Rx, w_Rx_Last, w_Rx_Mid, w_Rx_Clear;
`ifdef UART_RX_FRAME_ERR_EN
    logic            r_Rx_Frame_Err;
`endif

    assign w_Rx = r_Rx_Sync2;
    // Re-centre the timer on the middle of the start bit so every later
    // sample lands mid-bit one full period apart.
    assign w_Rx_Clear = (r_Rx_State == IDLE) || (r_Rx_State == START && w_Rx_Mid);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Clear (w_Rx_Clear),
        .o_Last  (w_Rx_Last),
        .o_Mid   (w_Rx_Mid)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Rx_Sync1 <= 1'b1;
            r_Rx_Sync2 <= 1'b1;
        end else begin
            r_Rx_Sync1 <= i_Rx_Serial;
            r_Rx_Sync2 <= r_Rx_Sync1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Rx_State <= IDLE;
            r_Rx_Data  <= '0;
            r_Rx_Byte  <= '0;
            r_Rx_Idx   <= '0;
            r_Rx_DV    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_Rx_Frame_Err <= 1'b0;
`endif
        end else begin
            r_Rx_DV <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_Rx_Frame_Err <= 1'b0;
`endif
            case (r_Rx_State)
                IDLE: begin
                    r_Rx_Idx <= '0;
                    if (!w_Rx) r_Rx_State <= START;
                end
                START: if (w_Rx_Mid) r_Rx_State <= w_Rx ? IDLE : DATA;
                DATA: if (w_Rx_Last) begin
                    r_Rx_Data[r_Rx_Idx] <= w_Rx;
                    if (r_Rx_Idx == LAST_IDX)
                        r_Rx_State <= STOP;
                    else
                        r_Rx_Idx <= r_Rx_Idx + IW'(1);
                end
                STOP: if (w_Rx_Last) begin
`ifdef UART_RX_FRAME_ERR_EN
                    if (w_Rx) begin
                        r_Rx_Byte <= r_Rx_Data;
                        r_Rx_DV   <= 1'b1;
                    end else begin
                        r_Rx_Frame_Err <= 1'b1;
                    end
`else
                    r_Rx_Byte <= r_Rx_Data;
                    r_Rx_DV   <= 1'b1;
`endif
                    r_Rx_State <= CLEANUP;
                end
                CLEANUP: r_Rx_State <= IDLE;
                default: r_Rx_State <= IDLE;
            endcase
        end
    end

    assign o_Rx_DV   = r_Rx_DV;
    assign o_Rx_Byte = r_Rx_Byte;
`ifdef UART_RX_FRAME_ERR_EN
    assign o_Rx_Frame_Err = r_Rx_Frame_Err;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: TX frame shape/timing, RX decode with
// skewed bit periods, glitch rejection, ignored mid-frame strobes, loopback, mid-frame reset.
`timescale 1ns/1ps
module tb_uart_transceiver;

    localparam int CLKS   = 1085;
    localparam int WORD   = 9;
    localparam int CLK_NS = 8;
    localparam int BIT_NS = CLKS * CLK_NS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tx_dv = 1'b0;
    logic [WORD-1:0] tx_byte = '0;
    logic            tx_active, tx_serial, tx_done, rx_dv;
    logic [WORD-1:0] rx_byte;
    logic            rx_drv = 1'b1;
    logic            loopback = 1'b0;
    logic            rx_in;
`ifdef UART_RX_FRAME_ERR_EN
    logic            rx_ferr;
`endif

    int checks = 0;
    int errors = 0;
    int rx_dv_cnt = 0;
    int tx_done_cnt = 0;
    logic [WORD-1:0] rx_last = '0;

    assign rx_in = loopback ? tx_serial : rx_drv;

    always #(CLK_NS/2) clk = ~clk;

    uart_transceiver #(.CLKS_PER_BIT(CLKS), .WORD(WORD)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Tx_DV        (tx_dv),
        .i_Tx_Byte      (tx_byte),
        .o_Tx_Active    (tx_active),
        .o_Tx_Serial    (tx_serial),
        .o_Tx_Done      (tx_done),
        .i_Rx_Serial    (rx_in),
        .o_Rx_DV        (rx_dv),
`ifdef UART_RX_FRAME_ERR_EN
        .o_Rx_Frame_Err (rx_ferr),
`endif
        .o_Rx_Byte      (rx_byte)
    );

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            rx_dv_cnt++;
            rx_last = rx_byte;
        end
        if (tx_done === 1'b1) tx_done_cnt++;
    end

    // Strobe a word into TX and compare every cycle of the frame against the
    // ideal waveform {stop, word, start}, each level lasting CLKS cycles.
    task automatic tx_frame_check(input logic [WORD-1:0] w, input int inj_c, input string name);
        logic [WORD+1:0] f;
        logic [WORD+1:0] obs;
        int bad_cyc = 0;
        int act_bad = 0;
        int done_bad = 0;
        f   = {1'b1, w, 1'b0};
        obs = 'x;
        @(negedge clk); tx_dv = 1'b1; tx_byte = w;
        @(negedge clk); tx_dv = 1'b0;
        for (int c = 0; c < (WORD + 2) * CLKS; c++) begin
            if (c == inj_c) begin
                tx_dv = 1'b1; tx_byte = 9'h155;
            end else if (c == inj_c + 1) begin
                tx_dv = 1'b0;
            end
            if (tx_serial !== f[c / CLKS]) bad_cyc++;
            if (c % CLKS == CLKS / 2) obs[c / CLKS] = tx_serial;
            if (tx_active !== 1'b1) act_bad++;
            if (tx_done !== 1'b0) done_bad++;
            @(negedge clk);
        end
        for (int b = 0; b < WORD + 2; b++) begin
            checks++;
            if (obs[b] !== f[b]) begin
                errors++;
                $display("FAIL %s bit%0d: got %b expected %b", name, b, obs[b], f[b]);
            end
        end
        checks++;
        if (bad_cyc !== 0) begin
            errors++; $display("FAIL %s edge_timing: %0d wrong cycles, expected 0", name, bad_cyc);
        end
        checks++;
        if (act_bad !== 0) begin
            errors++; $display("FAIL %s active_span: %0d low cycles, expected 0", name, act_bad);
        end
        checks++;
        if (done_bad !== 0) begin
            errors++; $display("FAIL %s early_done: %0d cycles, expected 0", name, done_bad);
        end
        checks++;
        if ({tx_done, tx_active, tx_serial} !== 3'b101) begin
            errors++; $display("FAIL %s end_of_frame: done/active/serial=%b%b%b expected 101",
                               name, tx_done, tx_active, tx_serial);
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b0) begin
            errors++; $display("FAIL %s done_width: got %b expected 0", name, tx_done);
        end
    endtask

    // Drive one serial frame with an arbitrary bit period and start-bit stretch.
    task automatic rx_frame(input logic [WORD-1:0] w, input int bit_ns, input int extra_ns, input string name);
        int base;
        base = rx_dv_cnt;
        rx_drv = 1'b0;
        #(bit_ns + extra_ns);
        for (int i = 0; i < WORD; i++) begin
            rx_drv = w[i];
            #(bit_ns);
        end
        rx_drv = 1'b1;
        #(bit_ns - 100);
        checks++;
        if (rx_dv_cnt - base !== 1) begin
            errors++; $display("FAIL %s dv_count: got %0d expected 1", name, rx_dv_cnt - base);
        end
        checks++;
        if (rx_byte !== w) begin
            errors++; $display("FAIL %s rx_byte: got %h expected %h", name, rx_byte, w);
        end
        #100;
        repeat (20) @(negedge clk);
        checks++;
        if (rx_dv_cnt - base !== 1) begin
            errors++; $display("FAIL %s dv_after: got %0d expected 1", name, rx_dv_cnt - base);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_serial, tx_active, tx_done, rx_dv} !== 4'b1000) begin
            errors++; $display("FAIL reset_lines: serial/active/done/dv=%b%b%b%b expected 1000",
                               tx_serial, tx_active, tx_done, rx_dv);
        end
        checks++;
        if (rx_byte !== '0) begin
            errors++; $display("FAIL reset_rx_byte: got %h expected 000", rx_byte);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx_ignore_dv();
        int base;
        base = tx_done_cnt;
        tx_frame_check(9'h0AB, 5 * CLKS + 17, "tx_0AB");
        checks++;
        if (tx_done_cnt - base !== 1) begin
            errors++; $display("FAIL tx_done_count: got %0d expected 1", tx_done_cnt - base);
        end
    endtask

    task automatic test_rx_late_start();
        rx_frame(9'h03F, 8600, 1000, "rx_03F");
    endtask

    // Glitch first, then a random skewed frame; TX runs a random word concurrently.
    task automatic test_glitch_duplex();
        logic [WORD-1:0] wt, wr;
        int per, ext;
        wt  = WORD'($urandom_range(0, 511));
        wr  = WORD'($urandom_range(0, 511));
        per = BIT_NS - 170 + int'($urandom_range(0, 340));
        ext = int'($urandom_range(0, 1000));
        fork
            tx_frame_check(wt, -1, "tx_rand");
            begin
                rx_drv = 1'b0; #200; rx_drv = 1'b1;
                repeat (2 * CLKS) @(negedge clk);
                checks++;
                if (rx_dv === 1'b1 || rx_dv_cnt !== 1) begin
                    errors++; $display("FAIL glitch_dv: dv count %0d expected 1", rx_dv_cnt);
                end
                rx_frame(wr, per, ext, "rx_rand");
            end
        join
    endtask

    task automatic test_loopback(input logic [WORD-1:0] w, input string name);
        int base;
        base = rx_dv_cnt;
        tx_frame_check(w, -1, name);
        repeat (5) @(negedge clk);
        checks++;
        if (rx_dv_cnt - base !== 1) begin
            errors++; $display("FAIL %s loop_dv: got %0d expected 1", name, rx_dv_cnt - base);
        end
        checks++;
        if (rx_last !== w) begin
            errors++; $display("FAIL %s loop_byte: got %h expected %h", name, rx_last, w);
        end
    endtask

    task automatic test_reset_midframe();
        int tb, rb;
        tb = tx_done_cnt;
        rb = rx_dv_cnt;
        @(negedge clk); tx_dv = 1'b1; tx_byte = 9'h10F;
        @(negedge clk); tx_dv = 1'b0;
        repeat (5 * CLKS) @(negedge clk);
        checks++;
        if ({tx_active, tx_serial} !== 2'b10) begin
            errors++; $display("FAIL midframe_state: active/serial=%b%b expected 10", tx_active, tx_serial);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_serial, tx_active, tx_done} !== 3'b100) begin
            errors++; $display("FAIL abort_lines: serial/active/done=%b%b%b expected 100",
                               tx_serial, tx_active, tx_done);
        end
        checks++;
        if (rx_byte !== '0) begin
            errors++; $display("FAIL abort_rx_byte: got %h expected 000", rx_byte);
        end
        rst = 1'b0;
        repeat (7 * CLKS) @(negedge clk);
        checks++;
        if (tx_done_cnt !== tb || rx_dv_cnt !== rb) begin
            errors++; $display("FAIL abort_pulses: done %0d dv %0d expected %0d %0d",
                               tx_done_cnt, rx_dv_cnt, tb, rb);
        end
    endtask

    initial begin
        test_reset();
        test_tx_ignore_dv();
        test_rx_late_start();
        test_glitch_duplex();
        loopback = 1'b1;
        test_loopback(9'h1FF, "loop_1FF");
        test_loopback(9'h000, "loop_000");
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
